// File: rtl/count_disp_pkg.sv
// count_disp_pkg: shared types and constants for count_display_driver.
// Holds the scan FSM state enum and the active-low 7-seg patterns.
package count_disp_pkg;

  typedef enum logic [1:0] {
    SHOW_ONES,
    GAP_A,
    SHOW_TENS,
    GAP_B
  } state_e;

  // Active-low patterns, bit order g..a (seg[6]=g, seg[0]=a).
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: 4-bit digit to active-low 7-segment pattern.
// Ports: digit_i (0-9 meaningful), seg_o (g..a); 10-15 decode blank.
module seg7_decode
  import count_disp_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_display_driver.sv
// count_display_driver: scans a 0-15 count onto a 2-digit common-anode
// 7-seg display in decimal, snapshotting count once per frame.
// Ports: clk, reset (async, active-high), count[3:0] in;
//   seg[6:0] (active-low, g..a), an[1:0] (active-low, [0]=ones),
//   frame_tick (1-cycle pulse on first cycle of each frame) out.
// Option: LEAD_ZERO_BLANK_EN blanks the tens digit when it is 0.
module count_display_driver
  import count_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int MAXN =
    (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int TW = $clog2(MAXN);

  localparam logic [TW-1:0] SHOW_LAST =
    TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST =
    TW'(GAP_CYCLES - 1);

  state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic [6:0] seg_q, seg_d;
  logic [1:0] an_q, an_d;
  logic tick_q, tick_d;

  logic [TW-1:0] last;
  logic done;
  logic [3:0] digit;
  logic [6:0] pat;

  seg7_decode u_dec (
    .digit_i (digit),
    .seg_o   (pat)
  );

  always_comb begin
    last = GAP_LAST;
    if (state_q == SHOW_ONES ||
        state_q == SHOW_TENS)
      last = SHOW_LAST;
    done = (timer_q == last);
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    ones_d  = ones_q;
    tens_d  = tens_q;
    tick_d  = 1'b0;
    if (done) begin
      timer_d = '0;
      unique case (state_q)
        SHOW_ONES: state_d = GAP_A;
        GAP_A:     state_d = SHOW_TENS;
        SHOW_TENS: state_d = GAP_B;
        GAP_B:     state_d = SHOW_ONES;
        default:   state_d = GAP_B;
      endcase
    end
    // Frame start: latch count so the ones digit shows it this edge.
    if (done && state_q == GAP_B) begin
      tick_d = 1'b1;
      if (count >= 4'd10) begin
        tens_d = 4'd1;
        ones_d = count - 4'd10;
      end else begin
        tens_d = 4'd0;
        ones_d = count;
      end
    end
  end

  // Outputs follow next state so they change on the entry edge.
  always_comb begin
    digit = ones_d;
    if (state_d == SHOW_TENS)
      digit = tens_d;
    an_d  = 2'b11;
    seg_d = SEG_BLANK;
    unique case (state_d)
      SHOW_ONES: begin
        an_d  = 2'b10;
        seg_d = pat;
      end
      SHOW_TENS: begin
`ifdef LEAD_ZERO_BLANK_EN
        if (tens_d != 4'd0) begin
          an_d  = 2'b01;
          seg_d = pat;
        end
`else
        an_d  = 2'b01;
        seg_d = pat;
`endif
      end
      default: begin
        an_d  = 2'b11;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= GAP_B;
      timer_q <= '0;
      ones_q  <= '0;
      tens_q  <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= 2'b11;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule
